// File: rtl/cmlk_3d_frame_ctrl_pkg.sv
// Shared definitions for the 3D frame capture controller: FSM encoding and
// default timing constants.
package cmlk_3d_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_INIT       = 3'd1,
    S_WAIT_TRIG  = 3'd2,
    S_START      = 3'd3,
    S_CAPTURE    = 3'd4,
    S_WAIT_STORE = 3'd5,
    S_ERR        = 3'd6
  } state_e;

  localparam int DEF_INIT_CYCLES = 4;
  localparam int DEF_TMO_CYCLES  = 65535;

endpackage

// File: rtl/cmlk_3d_frame_ctrl.sv
// Frame capture sequencer: arms the image packer, gates sample writes per
// trigger, counts stored frames and reports overflow/timeout errors.
module cmlk_3d_frame_ctrl
  import cmlk_3d_frame_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES = DEF_INIT_CYCLES,
  parameter int TMO_CYCLES  = DEF_TMO_CYCLES
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        ctrl_start,
  input  logic        ctrl_stop,
  input  logic [15:0] cfg_frame_num,
  input  logic [23:0] cfg_frame_len,
  input  logic [1:0]  cfg_frame_type,
  input  logic        trig,
  input  logic        nom_out_vld,
  input  logic        frame_store,
  input  logic        fifo_overflow,
  output logic        init_txn,
  output logic        frame_start,
  output logic [1:0]  frame_type_o,
  output logic        wr2ddr_en,
  output logic        busy,
  output logic        done,
  output logic        err_ovf,
  output logic        err_tmo,
  output logic [15:0] frame_cnt
);

  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int TMO_W  = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TMO_CYCLES - 1);

  state_e            state;
  logic [15:0]       lat_frame_num;
  logic [23:0]       lat_frame_len;
  logic [1:0]        lat_frame_type;
  logic              stop_flag;
  logic [INIT_W-1:0] init_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [23:0]       sample_cnt;

  logic [23:0]       sample_nxt;
  logic [15:0]       frame_cnt_nxt;
  logic              arm;
  logic              last_frame;

  assign sample_nxt    = sample_cnt + 24'd1;
  assign frame_cnt_nxt = (frame_cnt == 16'hFFFF) ? frame_cnt : frame_cnt + 16'd1;
  assign arm           = ctrl_start && (cfg_frame_len != '0);
  // A stop requested in the same cycle as the store still ends the run.
  assign last_frame    = ((lat_frame_num != '0) && (frame_cnt_nxt == lat_frame_num))
                         || stop_flag || ctrl_stop;

  // NOTE: every register here is assigned with <= so all next-state values are
  // computed from the same pre-edge snapshot; blocking = would create ordering races.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state          <= S_IDLE;
      lat_frame_num  <= '0;
      lat_frame_len  <= '0;
      lat_frame_type <= '0;
      stop_flag      <= 1'b0;
      init_cnt       <= '0;
      tmo_cnt        <= '0;
      sample_cnt     <= '0;
      init_txn       <= 1'b0;
      frame_start    <= 1'b0;
      frame_type_o   <= '0;
      wr2ddr_en      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_ovf        <= 1'b0;
      err_tmo        <= 1'b0;
      frame_cnt      <= '0;
    end else begin
      done        <= 1'b0;
      frame_start <= 1'b0;

      if (state == S_IDLE || state == S_ERR) begin
        if (arm) begin
          lat_frame_num  <= cfg_frame_num;
          lat_frame_len  <= cfg_frame_len;
          lat_frame_type <= cfg_frame_type;
          frame_cnt      <= '0;
          err_ovf        <= 1'b0;
          err_tmo        <= 1'b0;
          stop_flag      <= 1'b0;
          init_cnt       <= '0;
          init_txn       <= 1'b1;
          busy           <= 1'b1;
          state          <= S_INIT;
        end else if (state == S_ERR && ctrl_stop) begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      end else if (fifo_overflow) begin
        // Overflow wins over frame_store and the timeout in the same cycle.
        err_ovf   <= 1'b1;
        init_txn  <= 1'b0;
        wr2ddr_en <= 1'b0;
        state     <= S_ERR;
      end else begin
        if (ctrl_stop && state != S_WAIT_TRIG) begin
          stop_flag <= 1'b1;
        end

        case (state)
          S_INIT: begin
            if (init_cnt == INIT_LAST) begin
              init_txn <= 1'b0;
              state    <= S_WAIT_TRIG;
            end else begin
              init_cnt <= init_cnt + 1'b1;
            end
          end

          S_WAIT_TRIG: begin
            if (ctrl_stop) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else if (trig) begin
              frame_start  <= 1'b1;
              frame_type_o <= lat_frame_type;
              state        <= S_START;
            end
          end

          S_START: begin
            sample_cnt <= '0;
            wr2ddr_en  <= 1'b1;
            state      <= S_CAPTURE;
          end

          S_CAPTURE: begin
            if (nom_out_vld) begin
              sample_cnt <= sample_nxt;
              if (sample_nxt == lat_frame_len) begin
                wr2ddr_en <= 1'b0;
                tmo_cnt   <= '0;
                state     <= S_WAIT_STORE;
              end
            end
          end

          S_WAIT_STORE: begin
            if (frame_store) begin
              frame_cnt <= frame_cnt_nxt;
              if (last_frame) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_IDLE;
              end else begin
                state <= S_WAIT_TRIG;
              end
            end else if (tmo_cnt == TMO_LAST) begin
              err_tmo <= 1'b1;
              state   <= S_ERR;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/cmlk_3d_frame_ctrl.md
CMLK_3D_FRAME_CTRL -- requirements
Module: cmlk_3d_frame_ctrl

Interface
REQ-001 SHALL have parameter INIT_CYCLES, default 4, init_txn pulse length in cycles (min 1).
REQ-002 SHALL have parameter TMO_CYCLES, default 65535, frame_store timeout in cycles.
REQ-003 SHALL have ports: aclk in 1 (single clock); areset in 1 (synchronous, active-high reset).
REQ-004 SHALL have ports: ctrl_start in 1 (arm pulse); ctrl_stop in 1 (stop-request pulse).
REQ-005 SHALL have ports: cfg_frame_num in 16 (frames per run, 0 = continuous); cfg_frame_len in 24 (input samples per frame); cfg_frame_type in 2.
REQ-006 SHALL have ports: trig in 1 (frame trigger pulse); nom_out_vld in 1 (input sample strobe); frame_store in 1 (packer frame-stored pulse); fifo_overflow in 1 (packer overflow).
REQ-007 SHALL have outputs: init_txn 1 (packer reset); frame_start 1 (pulse); frame_type_o 2; wr2ddr_en 1.
REQ-008 SHALL have outputs: busy 1; done 1 (pulse); err_ovf 1 (sticky); err_tmo 1 (sticky); frame_cnt 16 (completed frames).

Function
REQ-009 SHALL implement FSM states IDLE, INIT, WAIT_TRIG, START, CAPTURE, WAIT_STORE, ERR.
REQ-010 IDLE: ctrl_start with cfg_frame_len != 0 SHALL latch all cfg_* inputs, clear frame_cnt, err_ovf, err_tmo and stop flag, and enter INIT; ctrl_start with cfg_frame_len == 0 SHALL be ignored.
REQ-011 INIT: init_txn SHALL be high for exactly INIT_CYCLES cycles, then go to WAIT_TRIG.
REQ-012 WAIT_TRIG: trig SHALL go to START; trig in any other state SHALL be ignored.
REQ-013 START: frame_start SHALL be high for exactly one cycle; frame_type_o SHALL equal the latched type from START until the next ctrl_start; next state CAPTURE.
REQ-014 CAPTURE: wr2ddr_en SHALL be high; a 24-bit sample counter SHALL count nom_out_vld; the cycle the count reaches latched cfg_frame_len, wr2ddr_en SHALL drop next cycle and state SHALL become WAIT_STORE.
REQ-015 WAIT_STORE: frame_store SHALL increment frame_cnt.
REQ-016 After frame_store, if frame_cnt equals a non-zero latched cfg_frame_num, or the stop flag is set, the FSM SHALL pulse done for one cycle and return to IDLE; otherwise it SHALL return to WAIT_TRIG.
REQ-017 WAIT_STORE: if TMO_CYCLES cycles pass without frame_store, the block SHALL set err_tmo and enter ERR.
REQ-018 ctrl_stop in WAIT_TRIG SHALL go to IDLE with done pulsed.
REQ-019 ctrl_stop in INIT, START, CAPTURE or WAIT_STORE SHALL set the stop flag; the current frame SHALL complete normally.
REQ-020 fifo_overflow high in INIT..WAIT_STORE SHALL set err_ovf and enter ERR next cycle, deasserting wr2ddr_en; overflow SHALL take priority over frame_store and the timeout in the same cycle.
REQ-021 ERR: outputs SHALL be idle except busy=1 and the sticky error flags; ctrl_start SHALL behave as in IDLE, and ctrl_stop SHALL go to IDLE without done.
REQ-022 busy SHALL be high in every state except IDLE.
REQ-023 frame_cnt SHALL saturate at 0xFFFF in continuous mode.
REQ-024 ctrl_start outside IDLE and ERR SHALL be ignored.

Reset
REQ-025 areset SHALL force IDLE.
REQ-026 areset SHALL clear all counters, flags and outputs, including frame_type_o = 0 and frame_cnt = 0.
REQ-027 areset mid-frame SHALL drop wr2ddr_en on the next clock edge.
REQ-028 areset SHALL NOT produce a done pulse.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding and the default constants INIT_CYCLES and TMO_CYCLES.
REQ-030 The block SHALL be a single module with no sub-modules, sitting above cmlk_3d_img_pack_wrapper, which receives its init_txn, frame_start, frame_type_o and wr2ddr_en.

Verification
REQ-031 Scenario: frame_num=2, len=8, type=2, two trigs, 8 vld each, frame_store each time -> init_txn high 4 cycles, frame_start pulsed twice, frame_type_o=2, frame_cnt=2, one done.
REQ-032 Scenario: len=0, ctrl_start -> state stays IDLE, busy=0.
REQ-033 Scenario: overflow at sample 5 of 8 -> err_ovf=1, wr2ddr_en=0 next cycle, ERR; then ctrl_stop -> IDLE, no done.
REQ-034 Scenario: TMO_CYCLES=16, no frame_store -> err_tmo=1 on cycle 16 of WAIT_STORE.
REQ-035 Scenario: frame_num=0, ctrl_stop at sample 3 of 8 -> frame completes, then done and IDLE with frame_cnt=1.
REQ-036 Scenario: areset asserted in CAPTURE -> all outputs 0 next cycle, no done.
